ahb_ep_fifo_slave: RTL

//  AHB-Lite slave endpoint buffer for the USB bulk endpoint: a parametrised circular byte FIFO shared by the
//  AHB host side and the USB RX/TX packet datapaths, plus memory-mapped status/control registers.

---
 rtl/ahb_ep_fifo_slave.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_ep_fifo_slave.sv
// rtl/ahb_ep_fifo_slave.sv - AHB-Lite endpoint FIFO slave with status/control registers
module ahb_ep_fifo_slave #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 7,
    parameter int STATUS_BASE = 64
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    hsel,
    input  logic                    hwrite,
    input  logic [ADDR_W-1:0]       haddr,
    input  logic [1:0]              htrans,
    input  logic [1:0]              hsize,
    input  logic [31:0]             hwdata,
    output logic [31:0]             hrdata,
    output logic                    hresp,
    output logic                    hready,
    input  logic                    rx_data_ready,
    input  logic                    rx_transfer_active,
    input  logic                    rx_error,
    input  logic                    tx_transfer_active,
    input  logic                    tx_error,
    input  logic                    clear,
    output logic                    buffer_reserved,
    output logic [7:0]              tx_packet_data_size,
    output logic [$clog2(DEPTH):0]  buffer_occupancy,
    input  logic                    get_tx_packet_data,
    output logic [7:0]              tx_packet_data,
    input  logic                    store_rx_packet_data,
    input  logic [7:0]              rx_packet_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_ERR1 = 2'd2, S_ERR2 = 2'd3;
    localparam logic [2:0] R_STATUS = 3'd0, R_ERR = 3'd1, R_OCC = 3'd2, R_TXSIZE = 3'd3, R_CTRL = 3'd4;

    logic [1:0]        state, state_n;
    logic [7:0]        mem [DEPTH];
    logic [PW-1:0]     wptr, rptr, occ;
    logic              overflow, underflow, tx_active_d;
    logic [1:0]        err_flags;
    logic [7:0]        tx_size;
    logic              dp_win, dp_write;
    logic [2:0]        dp_idx;
    logic [PW-1:0]     dp_bytes;

    assign occ                 = wptr - rptr;
    assign buffer_occupancy    = occ;
    assign tx_packet_data_size = tx_size;
    assign hready              = (state != S_ERR1);
    assign hresp               = state[1];

    // Address-phase decode
    logic              in_data, a_valid, a_win, a_reg, a_misalign, a_legal;
    logic [PW-1:0]     a_bytes, pend_w, pend_r;
    logic [ADDR_W-1:0] a_off;
    logic [2:0]        a_idx;

    assign in_data    = (state == S_DATA);
    assign a_valid    = hsel & (htrans == 2'b10 || htrans == 2'b11) & (state != S_ERR1);
    assign a_bytes    = PW'(1) << hsize;
    assign a_win      = haddr < ADDR_W'(DEPTH);
    assign a_off      = haddr - ADDR_W'(STATUS_BASE);
    assign a_reg      = (haddr >= ADDR_W'(STATUS_BASE)) && (a_off <= ADDR_W'(16));
    assign a_idx      = a_off[4:2];
    assign a_misalign = (hsize == 2'd1 && haddr[0]) || (hsize == 2'd2 && haddr[1:0] != 2'b00);
    // Bytes still owed by the transfer in data phase count against free space / occupancy
    assign pend_w     = (in_data & dp_win & dp_write)  ? dp_bytes : '0;
    assign pend_r     = (in_data & dp_win & ~dp_write) ? dp_bytes : '0;

    always_comb begin
        a_legal = 1'b0;
        if (hsize == 2'd3 || a_misalign) begin
            a_legal = 1'b0;
        end else if (a_win) begin
            if (rx_transfer_active || tx_transfer_active)
                a_legal = 1'b0;
            else if (hwrite)
                a_legal = (a_bytes <= PW'(DEPTH) - occ - pend_w);
            else
                a_legal = (a_bytes <= occ - pend_r);
        end else if (a_reg && hsize == 2'd2) begin
            if (hwrite)
                a_legal = (a_idx != R_STATUS) && (a_idx != R_OCC);
            else
                a_legal = (a_idx != R_CTRL);
        end
    end

    always_comb begin
        state_n = S_IDLE;
        if (state == S_ERR1)
            state_n = S_ERR2;
        else if (a_valid)
            state_n = a_legal ? S_DATA : S_ERR1;
    end

    // Data-phase effects and the USB side ports
    logic          ahb_wr, ahb_rd, reg_wr, reg_rd, flush, tx_fall;
    logic          rx_full, tx_empty, do_push, do_pop;
    logic [PW-1:0] wptr_mid, rptr_mid;

    assign ahb_wr   = in_data & dp_win & dp_write;
    assign ahb_rd   = in_data & dp_win & ~dp_write;
    assign reg_wr   = in_data & ~dp_win & dp_write;
    assign reg_rd   = in_data & ~dp_win & ~dp_write;
    assign flush    = clear | (reg_wr && dp_idx == R_CTRL && hwdata[0]);
    assign tx_fall  = tx_active_d & ~tx_transfer_active;
    assign wptr_mid = wptr + (ahb_wr ? dp_bytes : '0);
    assign rptr_mid = rptr + (ahb_rd ? dp_bytes : '0);
    assign rx_full  = (wptr_mid - rptr) == PW'(DEPTH);
    assign tx_empty = (wptr == rptr_mid);
    assign do_push  = store_rx_packet_data & ~rx_full & ~flush;
    assign do_pop   = get_tx_packet_data & ~tx_empty & ~flush;

    always_comb begin
        hrdata = '0;
        if (ahb_rd) begin
            for (int i = 0; i < 4; i++)
                if (PW'(i) < dp_bytes)
                    hrdata[8*i +: 8] = mem[AW'(rptr + PW'(i))];
        end else if (reg_rd) begin
            case (dp_idx)
                R_STATUS: hrdata = {27'd0, underflow, overflow, tx_transfer_active,
                                    rx_transfer_active, rx_data_ready};
                R_ERR:    hrdata = {30'd0, err_flags};
                R_OCC:    hrdata = {{(32-PW){1'b0}}, occ};
                R_TXSIZE: hrdata = {24'd0, tx_size};
                default:  hrdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= S_IDLE;
            wptr            <= '0;
            rptr            <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
            err_flags       <= '0;
            tx_size         <= '0;
            buffer_reserved <= 1'b0;
            tx_active_d     <= 1'b0;
            tx_packet_data  <= '0;
            dp_win          <= 1'b0;
            dp_write        <= 1'b0;
            dp_idx          <= '0;
            dp_bytes        <= '0;
        end else begin
            state       <= state_n;
            tx_active_d <= tx_transfer_active;
            if (a_valid && a_legal) begin
                dp_win   <= a_win;
                dp_write <= hwrite;
                dp_idx   <= a_idx;
                dp_bytes <= a_bytes;
            end
            err_flags <= ((reg_wr && dp_idx == R_ERR) ? (err_flags & ~hwdata[1:0]) : err_flags)
                         | {tx_error, rx_error};
            if (reg_wr && dp_idx == R_TXSIZE)
                tx_size <= hwdata[7:0];
            else if (tx_fall)
                tx_size <= '0;
            if (flush) begin
                wptr            <= '0;
                rptr            <= '0;
                overflow        <= 1'b0;
                underflow       <= 1'b0;
                buffer_reserved <= 1'b0;
            end else begin
                wptr <= wptr_mid + PW'(do_push);
                rptr <= rptr_mid + PW'(do_pop);
                if (store_rx_packet_data && rx_full)
                    overflow <= 1'b1;
                if (get_tx_packet_data && tx_empty)
                    underflow <= 1'b1;
                if (tx_fall)
                    buffer_reserved <= 1'b0;
                else if (ahb_wr)
                    buffer_reserved <= 1'b1;
            end
            if (get_tx_packet_data && !flush)
                tx_packet_data <= tx_empty ? 8'd0 : mem[rptr_mid[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (ahb_wr && !flush) begin
            for (int i = 0; i < 4; i++)
                if (PW'(i) < dp_bytes)
                    mem[AW'(wptr + PW'(i))] <= hwdata[8*i +: 8];
        end
        if (do_push)
            mem[wptr_mid[AW-1:0]] <= rx_packet_data;
    end
endmodule
